grade_guess: RTL and testbench

//   Consumes the 12-bit masterPattern and masterLoaded produced by the master-pattern loader.

---
 rtl/mastermind_pkg.sv | 39 +++
 rtl/grade_guess_if.sv | 33 +++
 rtl/pattern_unpack.sv | 15 +
 rtl/grade_guess.sv | 129 ++++++++++++
 tb/tb_grade_guess.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the mastermind grading slice.
// Patterns pack four 3-bit shapes, slot i at bits [3i+2:3i].
package mastermind_pkg;

  typedef logic [2:0]  shape_t;
  typedef logic [11:0] pattern_t;

  localparam int     NUM_SLOTS  = 4;
  localparam int     NUM_SHAPES = 6;
  localparam shape_t SHAPE_MIN  = 3'b001;
  localparam shape_t SHAPE_MAX  = shape_t'(int'(SHAPE_MIN) + NUM_SHAPES - 1);

  typedef enum logic [1:0] {IDLE, MATCH, COUNT, DONE} grade_state_t;

  typedef shape_t slotArr_t [NUM_SLOTS];

  // Occurrences of one shape across the four slots (0..4).
  function automatic logic [2:0] countShape(input slotArr_t sl, input shape_t s);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (sl[i] == s) n = n + 3'd1;
    return n;
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  // A slot holding 000 or 111 is not a playable shape.
  function automatic logic isIllegal(input pattern_t p);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (p[3*i +: 3] == 3'b000 || p[3*i +: 3] == 3'b111) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/grade_guess_if.sv
// Guess handshake and grade result bundle between the player front end
// (master modport) and the grader (slave modport).
// GRADE_ILLEGAL_CHECK_EN adds the illegalGuess indication.
interface grade_guess_if;
  import mastermind_pkg::*;

  pattern_t    guess;
  logic        guessValid;
  logic        guessReady;
  logic [2:0]  znarly;
  logic [2:0]  zood;
  logic        gradeValid;
  logic [3:0]  roundNum;
  logic        gameWon;
  logic        gameOver;
`ifdef GRADE_ILLEGAL_CHECK_EN
  logic        illegalGuess;

  modport master (output guess, guessValid,
                  input  guessReady, znarly, zood, gradeValid, roundNum,
                         gameWon, gameOver, illegalGuess);
  modport slave  (input  guess, guessValid,
                  output guessReady, znarly, zood, gradeValid, roundNum,
                         gameWon, gameOver, illegalGuess);
`else
  modport master (output guess, guessValid,
                  input  guessReady, znarly, zood, gradeValid, roundNum,
                         gameWon, gameOver);
  modport slave  (input  guess, guessValid,
                  output guessReady, znarly, zood, gradeValid, roundNum,
                         gameWon, gameOver);
`endif
endinterface

// File: rtl/pattern_unpack.sv
// Splits a packed 12-bit pattern into its four shape slots.
module pattern_unpack
  import mastermind_pkg::*;
(
  input  pattern_t pattern,
  output slotArr_t slot
);

  // Pure wiring: slot i takes bits [3i+2:3i].
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++)
      slot[i] = pattern[3*i +: 3];
  end

endmodule

// File: rtl/grade_guess.sv
// Multi-cycle guess grader: exact matches over four MATCH cycles, common
// shapes over six COUNT cycles, result published with a one-cycle gradeValid.
// Optional macro GRADE_ILLEGAL_CHECK_EN rejects guesses containing 000/111.
module grade_guess
  import mastermind_pkg::*;
#(
  parameter int MAX_ROUNDS = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  pattern_t      masterPattern,
  input  logic          masterLoaded,
  input  logic          startGame,
  grade_guess_if.slave  gg
);

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  grade_state_t state;
  pattern_t     guessLat;
  logic [1:0]   idx;
  shape_t       shapeSel;
  logic [2:0]   exact;
  logic [2:0]   common;

  slotArr_t     gSlot;
  slotArr_t     mSlot;

  // The master is read live so a grade in flight finishes even if
  // masterLoaded drops; the loader holds the pattern stable.
  pattern_unpack uGuess  (.pattern(guessLat),      .slot(gSlot));
  pattern_unpack uMaster (.pattern(masterPattern), .slot(mSlot));

  logic       accept;
  logic [2:0] exactNext;
  logic [2:0] commonNext;
  logic [3:0] roundNext;
  logic       wonNow;

  assign gg.guessReady = (state == IDLE) & masterLoaded & ~gg.gameOver;
  assign accept        = gg.guessValid & gg.guessReady;

  // Per-cycle accumulator updates and end-of-grade round bookkeeping.
  always_comb begin
    exactNext  = exact + {2'b00, (gSlot[idx] == mSlot[idx])};
    commonNext = common + min3(countShape(gSlot, shapeSel),
                               countShape(mSlot, shapeSel));
    roundNext  = (gg.roundNum == MAX_R) ? gg.roundNum : gg.roundNum + 4'd1;
    wonNow     = (exact == 3'd4);
  end

  // Grading FSM; results are registered on the last COUNT step so they
  // are visible during DONE together with gradeValid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      guessLat      <= '0;
      idx           <= '0;
      shapeSel      <= SHAPE_MIN;
      exact         <= '0;
      common        <= '0;
      gg.znarly     <= '0;
      gg.zood       <= '0;
      gg.gradeValid <= 1'b0;
      gg.roundNum   <= '0;
      gg.gameWon    <= 1'b0;
      gg.gameOver   <= 1'b0;
    end else if (startGame) begin
      state         <= IDLE;
      idx           <= '0;
      shapeSel      <= SHAPE_MIN;
      exact         <= '0;
      common        <= '0;
      gg.znarly     <= '0;
      gg.zood       <= '0;
      gg.gradeValid <= 1'b0;
      gg.roundNum   <= '0;
      gg.gameWon    <= 1'b0;
      gg.gameOver   <= 1'b0;
    end else begin
      gg.gradeValid <= 1'b0;
      case (state)
        IDLE: begin
`ifdef GRADE_ILLEGAL_CHECK_EN
          if (accept && !isIllegal(gg.guess)) begin
`else
          if (accept) begin
`endif
            guessLat <= gg.guess;
            idx      <= '0;
            shapeSel <= SHAPE_MIN;
            exact    <= '0;
            common   <= '0;
            state    <= MATCH;
          end
        end
        MATCH: begin
          exact <= exactNext;
          idx   <= idx + 2'd1;
          if (idx == 2'(NUM_SLOTS - 1)) state <= COUNT;
        end
        COUNT: begin
          common   <= commonNext;
          shapeSel <= shapeSel + 3'd1;
          if (shapeSel == SHAPE_MAX) begin
            state         <= DONE;
            gg.znarly     <= exact;
            gg.zood       <= commonNext - exact;
            gg.gradeValid <= 1'b1;
            gg.roundNum   <= roundNext;
            gg.gameWon    <= gg.gameWon | wonNow;
            gg.gameOver   <= gg.gameOver | gg.gameWon | wonNow | (roundNext == MAX_R);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRADE_ILLEGAL_CHECK_EN
  // One-cycle flag for a guess consumed without grading.
  always_ff @(posedge clock) begin
    if (reset || startGame) gg.illegalGuess <= 1'b0;
    else gg.illegalGuess <= accept & isIllegal(gg.guess);
  end
`endif

endmodule

// File: tb/tb_grade_guess.sv
// Self-checking bench for grade_guess: directed cases plus randomized games
// compared against a histogram-based scoring model.
module tb_grade_guess;
  import mastermind_pkg::*;

  localparam int MAXR = 8;

  logic     clock = 1'b0;
  logic     reset;
  pattern_t masterPattern;
  logic     masterLoaded;
  logic     startGame;

  grade_guess_if gg();

  grade_guess #(.MAX_ROUNDS(MAXR)) dut (
    .clock(clock), .reset(reset), .masterPattern(masterPattern),
    .masterLoaded(masterLoaded), .startGame(startGame), .gg(gg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model of game state.
  int mRound = 0;
  bit mWon = 0;
  bit mOver = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic pattern_t pk(input int s3, input int s2, input int s1, input int s0);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  function automatic pattern_t rndLegal();
    return pk($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6));
  endfunction

  // Scoring from the rules: exact slot matches, then per-shape min counts.
  task automatic score(input pattern_t m, input pattern_t g, output int ex, output int zo);
    int cm [8];
    int cg [8];
    int com;
    ex = 0; com = 0;
    for (int s = 0; s < 8; s++) begin cm[s] = 0; cg[s] = 0; end
    for (int i = 0; i < 4; i++) begin
      int a, b;
      a = int'(m[3*i +: 3]);
      b = int'(g[3*i +: 3]);
      if (a == b) ex++;
      cm[a]++; cg[b]++;
    end
    for (int s = 1; s <= 6; s++) com += (cm[s] < cg[s]) ? cm[s] : cg[s];
    zo = com - ex;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic newGame();
    startGame = 1'b1;
    tick();
    startGame = 1'b0;
    mRound = 0; mWon = 0; mOver = 0;
  endtask

  // Submit one guess and check the resulting grade against the model.
  task automatic doGuess(input string tag, input pattern_t g, input bit dropLoaded);
    int ex, zo, lat;
    bit got;
    score(masterPattern, g, ex, zo);
    gg.guess = g; gg.guessValid = 1'b1; #1;
    chk({tag, "_readyPre"}, int'(gg.guessReady), 1);
    tick();
    gg.guessValid = 1'b0;
    gg.guess = pattern_t'($urandom);
    got = 0; lat = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      if (dropLoaded && n == 3) masterLoaded = 1'b0;
      tick();
      if (gg.gradeValid) begin got = 1; lat = n + 1; end
    end
    chk({tag, "_latency"}, lat, 11);
    mRound = (mRound < MAXR) ? mRound + 1 : mRound;
    mWon   = mWon | (ex == 4);
    mOver  = mOver | mWon | (mRound == MAXR);
    chk({tag, "_znarly"}, int'(gg.znarly), ex);
    chk({tag, "_zood"}, int'(gg.zood), zo);
    chk({tag, "_round"}, int'(gg.roundNum), mRound);
    chk({tag, "_won"}, int'(gg.gameWon), int'(mWon));
    chk({tag, "_over"}, int'(gg.gameOver), int'(mOver));
    chk({tag, "_readyDone"}, int'(gg.guessReady), 0);
    tick();
    chk({tag, "_pulse"}, int'(gg.gradeValid), 0);
    chk({tag, "_readyAfter"}, int'(gg.guessReady), int'(!mOver && masterLoaded));
  endtask

  initial begin
    pattern_t g;
    int seen;
    reset = 1'b1; startGame = 1'b0; masterLoaded = 1'b0;
    masterPattern = '0; gg.guess = '0; gg.guessValid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_znarly", int'(gg.znarly), 0);
    chk("rst_zood", int'(gg.zood), 0);
    chk("rst_gradeValid", int'(gg.gradeValid), 0);
    chk("rst_round", int'(gg.roundNum), 0);
    chk("rst_won", int'(gg.gameWon), 0);
    chk("rst_over", int'(gg.gameOver), 0);

    // No master loaded: a presented guess must be held off.
    gg.guess = pk(1, 2, 3, 4); gg.guessValid = 1'b1;
    seen = 0;
    for (int n = 0; n < 14; n++) begin
      tick();
      if (gg.guessReady || gg.gradeValid) seen = 1;
    end
    chk("noMaster_held", seen, 0);
    chk("noMaster_round", int'(gg.roundNum), 0);
    gg.guessValid = 1'b0;

    // Game 1: master 001_010_011_100.
    masterPattern = pk(1, 2, 3, 4); masterLoaded = 1'b1;
    newGame();
    doGuess("rev", pk(4, 3, 2, 1), 0);
    doGuess("win", pk(1, 2, 3, 4), 0);
    chk("win_readyHeld", int'(gg.guessReady), 0);

    // Game 2: duplicates, then run out of rounds.
    masterPattern = pk(1, 1, 2, 2);
    newGame();
    chk("g2_round0", int'(gg.roundNum), 0);
    doGuess("dup", pk(1, 2, 1, 2), 0);
    doGuess("none", pk(3, 3, 3, 3), 0);
    for (int r = 0; r < 6; r++) begin
      do g = rndLegal(); while (g == masterPattern);
      doGuess("fill", g, 0);
    end
    chk("out_round", int'(gg.roundNum), MAXR);
    chk("out_over", int'(gg.gameOver), 1);
    chk("out_won", int'(gg.gameWon), 0);
    gg.guess = rndLegal(); gg.guessValid = 1'b1;
    seen = 0;
    for (int n = 0; n < 14; n++) begin
      tick();
      if (gg.guessReady || gg.gradeValid) seen = 1;
    end
    chk("ninth_held", seen, 0);
    chk("ninth_round", int'(gg.roundNum), MAXR);
    gg.guessValid = 1'b0;
    newGame();
    chk("restart_round", int'(gg.roundNum), 0);
    chk("restart_over", int'(gg.gameOver), 0);
    chk("restart_ready", int'(gg.guessReady), 1);

    // Abort a grade at cycle 6.
    doGuess("preAbort", pk(3, 3, 3, 3), 0);
    gg.guess = pk(1, 2, 1, 2); gg.guessValid = 1'b1;
    tick();
    gg.guessValid = 1'b0;
    repeat (5) tick();
    startGame = 1'b1;
    tick();
    startGame = 1'b0;
    mRound = 0; mWon = 0; mOver = 0;
    chk("abort_ready", int'(gg.guessReady), 1);
    chk("abort_znarly", int'(gg.znarly), 0);
    chk("abort_zood", int'(gg.zood), 0);
    chk("abort_round", int'(gg.roundNum), 0);
    seen = 0;
    for (int n = 0; n < 14; n++) begin
      tick();
      if (gg.gradeValid) seen = 1;
    end
    chk("abort_noGrade", seen, 0);

    // masterLoaded drops mid-grade: grade still completes.
    doGuess("drop", pk(2, 1, 1, 4), 1);
    masterLoaded = 1'b1;

`ifdef GRADE_ILLEGAL_CHECK_EN
    gg.guess = pk(0, 1, 2, 3); gg.guessValid = 1'b1;
    tick();
    gg.guessValid = 1'b0;
    chk("ill_pulse", int'(gg.illegalGuess), 1);
    chk("ill_round", int'(gg.roundNum), mRound);
    tick();
    chk("ill_pulseEnd", int'(gg.illegalGuess), 0);
    chk("ill_ready", int'(gg.guessReady), 1);
`endif

    // Randomized games.
    for (int gm = 0; gm < 4; gm++) begin
      masterPattern = rndLegal();
      newGame();
      while (!mOver) begin
        g = ($urandom_range(0, 5) == 0) ? masterPattern : rndLegal();
        doGuess("rnd", g, 0);
      end
      chk("rnd_readyOver", int'(gg.guessReady), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
